// File: rtl/xb_frame_parser_pkg.sv
// Shared definitions for the frame parser: sync constant, header layout, FSM states.
package xb_frame_parser_pkg;

  localparam logic [7:0] SYNC_WORD = 8'hA5;

  // Header word layout, MSB first: [31:24] sync, [23:16] opcode, [15:0] length.
  typedef struct packed {
    logic [7:0]  sync;
    logic [7:0]  opcode;
    logic [15:0] len;
  } hdr_t;

  typedef enum logic {
    ST_HDR     = 1'b0,
    ST_PAYLOAD = 1'b1
  } state_t;

endpackage

// File: rtl/xb_frame_parser_skid.sv
// One-entry output holding register with valid/ready handshake.
// A load always wins over a same-cycle drain, so back-to-back transfers
// keep valid high with the new contents.
module xfp_skid_reg #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         load,
  input  logic         ready,
  input  logic [W-1:0] din,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic         can_load
);

  // Free now, or will be freed by the handshake completing this cycle.
  assign can_load = !valid || ready;

  // Hold contents while stalled; load takes priority over drain.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/xb_frame_parser.sv
// Frame parser: pops words from a FWFT FIFO, decodes headers into a command
// register and streams payload words into a payload register. Malformed
// headers are dropped and counted.
module xb_frame_parser
  import xb_frame_parser_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MAX_LEN = 4096,
  parameter int DELAY   = 1
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_rden,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [7:0]       cmd_opcode,
  output logic [15:0]      cmd_len,
  output logic             pl_valid,
  input  logic             pl_ready,
  output logic [WIDTH-1:0] pl_data,
  output logic             pl_last,
  output logic [15:0]      err_cnt
);

  localparam logic [16:0] MAX_LEN_W = 17'(MAX_LEN);

  // DELAY only matters to behavioural models; the synthesized logic is zero-delay.
  logic unused_delay;
  assign unused_delay = (DELAY >= 0);

  state_t      state, state_nxt;
  logic [15:0] remain;
  logic        cmd_load, pl_load, err_inc;
  logic        cmd_can_load, pl_can_load;
  hdr_t        hdr;
  logic        hdr_good;

  assign hdr      = hdr_t'(fifo_dout[31:0]);
  assign hdr_good = (hdr.sync == SYNC_WORD) && ({1'b0, hdr.len} <= MAX_LEN_W);

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= ST_HDR;
    else          state <= state_nxt;
  end

  // Next state and pop/load strobes. Bad headers have no target register,
  // so they are popped regardless of consumer backpressure.
  always_comb begin
    state_nxt = state;
    fifo_rden = 1'b0;
    cmd_load  = 1'b0;
    pl_load   = 1'b0;
    err_inc   = 1'b0;
    if (RESET_N && !fifo_empty) begin
      case (state)
        ST_HDR: begin
          if (!hdr_good) begin
            fifo_rden = 1'b1;
            err_inc   = 1'b1;
          end else if (cmd_can_load) begin
            fifo_rden = 1'b1;
            cmd_load  = 1'b1;
            if (hdr.len != 16'd0) state_nxt = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (pl_can_load) begin
            fifo_rden = 1'b1;
            pl_load   = 1'b1;
            if (remain == 16'd1) state_nxt = ST_HDR;
          end
        end
        default: state_nxt = ST_HDR;
      endcase
    end
  end

  // Remaining payload words of the current frame.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)      remain <= 16'd0;
    else if (cmd_load) remain <= hdr.len;
    else if (pl_load)  remain <= remain - 16'd1;
  end

  // Discarded-word counter, sticks at all-ones.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                         err_cnt <= 16'd0;
    else if (err_inc && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
  end

  xfp_skid_reg #(.W(24)) u_cmd_reg (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .load     (cmd_load),
    .ready    (cmd_ready),
    .din      ({hdr.opcode, hdr.len}),
    .valid    (cmd_valid),
    .dout     ({cmd_opcode, cmd_len}),
    .can_load (cmd_can_load)
  );

  xfp_skid_reg #(.W(WIDTH + 1)) u_pl_reg (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .load     (pl_load),
    .ready    (pl_ready),
    .din      ({remain == 16'd1, fifo_dout}),
    .valid    (pl_valid),
    .dout     ({pl_last, pl_data}),
    .can_load (pl_can_load)
  );

endmodule

// File: tb/tb_xb_frame_parser.sv
// Bench for xb_frame_parser: frames are generated as transactions, expected
// commands/payload words/error count are queued at generation time and
// matched against DUT handshakes.
module tb_xb_frame_parser;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [31:0] fifo_dout = 32'h0;
  logic        fifo_rden;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [7:0]  cmd_opcode;
  logic [15:0] cmd_len;
  logic        pl_valid;
  logic        pl_ready = 1'b0;
  logic [31:0] pl_data;
  logic        pl_last;
  logic [15:0] err_cnt;

  always #5 CLK = ~CLK;

  xb_frame_parser #(.WIDTH(32), .MAX_LEN(4096), .DELAY(1)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rden  (fifo_rden),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_len    (cmd_len),
    .pl_valid   (pl_valid),
    .pl_ready   (pl_ready),
    .pl_data    (pl_data),
    .pl_last    (pl_last),
    .err_cnt    (err_cnt)
  );

  logic [31:0] q[$];
  logic [23:0] exp_cmd[$];
  logic [32:0] exp_pl[$];
  int          pl_cycs[$];
  int          exp_err = 0;
  int          n_chk = 0, n_fail = 0;
  int          cyc = 0, cmd_vcyc = 0, cmd_hs_cyc = 0, stall_seen = 0;
  bit          rand_mode = 0, gap = 0, stall_rden_chk = 0;
  bit          cmd_stall = 0, pl_stall = 0;
  logic [23:0] cmd_hold;
  logic [32:0] pl_hold;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty = gap || (q.size() == 0);
    fifo_dout  = (q.size() != 0) ? q[0] : 32'hDEAD_BEEF;
  endtask

  task automatic send_frame(input logic [7:0] op, input int len, input bit fixed = 0);
    logic [31:0] w;
    q.push_back({8'hA5, op, 16'(len)});
    exp_cmd.push_back({op, 16'(len)});
    for (int i = 0; i < len; i++) begin
      w = fixed ? 32'(11 * (i + 1)) : $urandom;
      q.push_back(w);
      exp_pl.push_back({1'(i == len - 1), w});
    end
    drive_fifo();
  endtask

  task automatic send_bad(input logic [31:0] w);
    q.push_back(w);
    if (exp_err < 65535) exp_err++;
    drive_fifo();
  endtask

  function automatic logic [31:0] rand_bad();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 1) == 1) begin
      w[31:24] = 8'hA5;
      w[15:0]  = 16'($urandom_range(4097, 65535));
    end else if (w[31:24] == 8'hA5) begin
      w[31:24] = 8'h5A;
    end
    return w;
  endfunction

  // One clock: observe at negedge, advance the FIFO model after posedge.
  task automatic cycle();
    bit pop;
    @(negedge CLK);
    if (fifo_empty) chk("rden_while_empty", fifo_rden, 0);
    if (cmd_valid) cmd_vcyc++;
    if (cmd_stall) chk("cmd_stable", {cmd_opcode, cmd_len}, cmd_hold);
    if (pl_stall)  chk("pl_stable", {pl_last, pl_data}, pl_hold);
    if (pl_valid && !pl_ready) begin
      stall_seen++;
      if (stall_rden_chk) chk("rden_in_stall", fifo_rden, 0);
    end
    if (cmd_valid && cmd_ready) begin
      cmd_hs_cyc = cyc;
      if (exp_cmd.size() == 0) chk("cmd_unexpected", 1, 0);
      else chk("cmd", {cmd_opcode, cmd_len}, exp_cmd.pop_front());
    end
    if (pl_valid && pl_ready) begin
      pl_cycs.push_back(cyc);
      if (exp_pl.size() == 0) chk("pl_unexpected", 1, 0);
      else chk("pl", {pl_last, pl_data}, exp_pl.pop_front());
    end
    cmd_stall = cmd_valid && !cmd_ready;
    cmd_hold  = {cmd_opcode, cmd_len};
    pl_stall  = pl_valid && !pl_ready;
    pl_hold   = {pl_last, pl_data};
    pop = fifo_rden;
    @(posedge CLK);
    #1;
    cyc++;
    if (pop && q.size() != 0) void'(q.pop_front());
    if (rand_mode) begin
      cmd_ready = 1'($urandom_range(0, 1));
      pl_ready  = 1'($urandom_range(0, 1));
      gap       = ($urandom_range(0, 3) == 0);
    end
    drive_fifo();
  endtask

  task automatic drain(input string tag, input int bound);
    int n = 0;
    while ((q.size() != 0 || exp_cmd.size() != 0 || exp_pl.size() != 0 ||
            cmd_valid || pl_valid) && n < bound) begin
      cycle();
      n++;
    end
    if (n >= bound) chk({tag, "_timeout"}, 1, 0);
    chk({tag, "_err_cnt"}, err_cnt, exp_err);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pat[4];
    int k;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    // Reset state, with a word offered so rden must stay masked.
    fifo_empty = 1'b0;
    fifo_dout  = 32'h1234_5678;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_rden", fifo_rden, 0);
    chk("rst_valids", {cmd_valid, pl_valid, pl_last}, 0);
    chk("rst_regs", {cmd_opcode, cmd_len, pl_data, err_cnt}, 0);
    fifo_empty = 1'b1;
    RESET_N = 1'b1;
    cmd_ready = 1'b1;
    pl_ready  = 1'b1;

    // Basic frame at full rate.
    cmd_vcyc = 0;
    pl_cycs.delete();
    q.push_back(32'hA501_0003);
    exp_cmd.push_back({8'h01, 16'd3});
    q.push_back(32'd11); exp_pl.push_back({1'b0, 32'd11});
    q.push_back(32'd22); exp_pl.push_back({1'b0, 32'd22});
    q.push_back(32'd33); exp_pl.push_back({1'b1, 32'd33});
    drive_fifo();
    drain("basic", 20);
    chk("basic_cmd_vcyc", cmd_vcyc, 1);
    chk("basic_pl_count", pl_cycs.size(), 3);
    if (pl_cycs.size() == 3) begin
      chk("basic_pl_lat", pl_cycs[0] - cmd_hs_cyc, 1);
      chk("basic_pl_tput", pl_cycs[2] - pl_cycs[0], 2);
    end

    // Bad word then zero-length header.
    send_bad(32'h1200_0002);
    send_frame(8'h07, 0);
    send_frame(8'h08, 1);
    drain("zero_len", 20);

    // Payload backpressure pattern 1,0,0,1.
    stall_seen = 0;
    stall_rden_chk = 1;
    send_frame(8'h3C, 4);
    k = 0;
    while ((q.size() != 0 || exp_pl.size() != 0 || exp_cmd.size() != 0 || pl_valid) && k < 40) begin
      pl_ready = pat[k % 4];
      cycle();
      k++;
    end
    stall_rden_chk = 0;
    pl_ready = 1'b1;
    chk("stall_stall_seen", stall_seen > 0, 1);
    drain("stall", 10);

    // Over-length header is dropped; the next header parses normally.
    send_bad(32'hA5AA_1001);
    send_frame(8'h42, 2);
    drain("overlen", 20);

    // Randomized traffic with bubbles and random backpressure.
    rand_mode = 1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) send_bad(rand_bad());
      else send_frame(8'($urandom), $urandom_range(0, 6));
    end
    drain("random", 3000);
    rand_mode = 0;
    gap = 1'b0;
    cmd_ready = 1'b1;
    pl_ready  = 1'b1;
    drive_fifo();

    // Reset mid-frame after the second of five payload words.
    send_frame(8'h55, 5);
    k = 0;
    while (exp_pl.size() > 3 && k < 30) begin
      cycle();
      k++;
    end
    if (k >= 30) chk("midrst_timeout", 1, 0);
    RESET_N = 1'b0;
    #1;
    chk("midrst_rden", fifo_rden, 0);
    chk("midrst_valids", {cmd_valid, pl_valid, pl_last}, 0);
    chk("midrst_regs", {cmd_opcode, cmd_len, pl_data, err_cnt}, 0);
    q.delete();
    exp_cmd.delete();
    exp_pl.delete();
    exp_err = 0;
    cmd_stall = 0;
    pl_stall  = 0;
    drive_fifo();
    @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    send_frame(8'h66, 2);
    drain("midrst", 20);

    // Saturation of the discard counter.
    for (int i = 0; i < 65536; i++) begin
      logic [31:0] w;
      w = $urandom;
      if (w[31:24] == 8'hA5) w[31:24] = 8'h00;
      send_bad(w);
    end
    drain("sat", 70000);
    chk("sat_err_cnt", err_cnt, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
